// File: rtl/timebase_timer_if.sv
// timebase_timer_if
//   Control/status bundle for timebase_timer.
//   master: drives enable/clear/arm/disarm, observes count/tick/wrap/armed/fire.
//   slave : the timer itself.
//   Signals:
//     enable, clear              prescaler run / synchronous clear
//     count[WIDTH], tick, wrap   timebase value and its pulses
//     arm_we, arm_sel[SEL_W], arm_delay[WIDTH], arm_periodic, disarm[NUM_CMP]
//     armed[NUM_CMP], fire[NUM_CMP]
interface timebase_timer_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_CMP = 2,
    parameter int SEL_W   = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1
);
    logic               enable;
    logic               clear;
    logic [WIDTH-1:0]   count;
    logic               tick;
    logic               wrap;
    logic               arm_we;
    logic [SEL_W-1:0]   arm_sel;
    logic [WIDTH-1:0]   arm_delay;
    logic               arm_periodic;
    logic [NUM_CMP-1:0] disarm;
    logic [NUM_CMP-1:0] armed;
    logic [NUM_CMP-1:0] fire;

    modport master (
        output enable, clear, arm_we, arm_sel, arm_delay, arm_periodic, disarm,
        input  count, tick, wrap, armed, fire
    );

    modport slave (
        input  enable, clear, arm_we, arm_sel, arm_delay, arm_periodic, disarm,
        output count, tick, wrap, armed, fire
    );
endinterface

// File: rtl/timebase_timer.sv
// timebase_timer
//   Free-running tick counter with NUM_CMP compare channels (one-shot or
//   periodic). A prescaler divides clk by DIV = CLK_HZ/TICK_HZ; count advances
//   once per tick and wraps mod 2^WIDTH. Each armed channel pulses fire[i]
//   for one cycle when count takes its target value.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    timebase_timer_if.slave (enable/clear, count/tick/wrap,
//            arm/disarm controls, armed/fire status)
module timebase_timer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1_000_000,
    parameter int WIDTH   = 32,
    parameter int NUM_CMP = 2,
    parameter int SEL_W   = (NUM_CMP > 1) ? $clog2(NUM_CMP) : 1
) (
    input  logic                clk,
    input  logic                reset,
    timebase_timer_if.slave     bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0]      r_presc;
    logic [WIDTH-1:0]   r_count;
    logic               r_tick;
    logic               r_wrap;
    logic [NUM_CMP-1:0] r_fire;
    logic [NUM_CMP-1:0] r_armed;
    logic [NUM_CMP-1:0] r_periodic;
    logic [WIDTH-1:0]   r_target [NUM_CMP];
    logic [WIDTH-1:0]   r_period [NUM_CMP];

    logic               w_tick_now;
    logic [WIDTH-1:0]   w_count_next;
    logic [WIDTH-1:0]   w_delay;
    logic [NUM_CMP-1:0] w_arm;
    logic [NUM_CMP-1:0] w_fire_now;

    always_comb begin
        w_arm        = '0;
        w_fire_now   = '0;
        w_tick_now   = bus.enable && (r_presc == PW'(DIV - 1));
        w_count_next = r_count + {{(WIDTH-1){1'b0}}, w_tick_now};
        w_delay      = (bus.arm_delay == '0) ? WIDTH'(1) : bus.arm_delay;
        for (int unsigned i = 0; i < NUM_CMP; i++) begin
            // arm_sel values >= NUM_CMP match no channel and are ignored
            w_arm[i] = bus.arm_we && (bus.arm_sel == SEL_W'(i));
            // Compare against the count this edge produces; a same-cycle arm
            // overrides disarm, so the due fire is still pulsed in that case.
            w_fire_now[i] = w_tick_now && r_armed[i] &&
                            (w_count_next == r_target[i]) &&
                            (w_arm[i] || !bus.disarm[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
            r_fire     <= '0;
            r_armed    <= '0;
            r_periodic <= '0;
            for (int unsigned i = 0; i < NUM_CMP; i++) begin
                r_target[i] <= '0;
                r_period[i] <= '0;
            end
        end else if (bus.clear) begin
            r_presc <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_fire  <= '0;
            r_armed <= '0;
        end else begin
            if (bus.enable) begin
                r_presc <= w_tick_now ? '0 : r_presc + PW'(1);
            end
            r_count <= w_count_next;
            r_tick  <= w_tick_now;
            r_wrap  <= w_tick_now && (r_count == '1);
            r_fire  <= w_fire_now;
            for (int unsigned i = 0; i < NUM_CMP; i++) begin
                if (w_arm[i]) begin
                    r_target[i]   <= w_count_next + w_delay;
                    r_period[i]   <= w_delay;
                    r_armed[i]    <= 1'b1;
                    r_periodic[i] <= bus.arm_periodic;
                end else if (bus.disarm[i]) begin
                    r_armed[i] <= 1'b0;
                end else if (w_fire_now[i]) begin
                    if (r_periodic[i]) begin
                        r_target[i] <= r_target[i] + r_period[i];
                    end else begin
                        r_armed[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tick  = r_tick;
    assign bus.wrap  = r_wrap;
    assign bus.fire  = r_fire;
    assign bus.armed = r_armed;
endmodule

// File: tb/tb_timebase_timer.sv
// tb_timebase_timer
//   Main DUT: DIV=4, WIDTH=8, NUM_CMP=3 (arm_sel value 3 is out of range).
//   Second DUT with default parameters checks the 50-clock tick rate.
//   A per-channel "ticks remaining" model predicts every output each cycle.
module tb_timebase_timer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    timebase_timer_if #(.WIDTH(8), .NUM_CMP(3)) tb_if ();
    timebase_timer_if d_if ();

    timebase_timer #(.CLK_HZ(4_000_000), .TICK_HZ(1_000_000), .WIDTH(8), .NUM_CMP(3))
        u_dut (.clk(clk), .reset(reset), .bus(tb_if));

    timebase_timer u_dflt (.clk(clk), .reset(reset), .bus(d_if));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: prescaler phase, tick count, per-channel ticks-to-go.
    int       m_presc, m_count;
    bit [2:0] m_armed, m_per;
    int       m_rem [3];
    int       m_period [3];
    bit       e_tick, e_wrap;
    bit [2:0] e_fire;

    task automatic model_reset();
        m_presc = 0; m_count = 0; m_armed = '0; m_per = '0;
        e_tick = 0; e_wrap = 0; e_fire = '0;
        for (int i = 0; i < 3; i++) begin m_rem[i] = 0; m_period[i] = 0; end
    endtask

    task automatic model_step();
        bit t, due, arm;
        int d;
        e_tick = 0; e_wrap = 0; e_fire = '0;
        if (tb_if.clear) begin
            m_presc = 0; m_count = 0; m_armed = '0;
            return;
        end
        t = tb_if.enable && (m_presc == 3);
        if (tb_if.enable) m_presc = (m_presc + 1) % 4;
        e_tick = t;
        if (t) begin
            m_count = (m_count + 1) % 256;
            e_wrap = (m_count == 0);
        end
        d = (tb_if.arm_delay == 0) ? 1 : int'(tb_if.arm_delay);
        for (int i = 0; i < 3; i++) begin
            due = 0;
            if (t && m_armed[i]) begin
                m_rem[i]--;
                due = (m_rem[i] == 0);
            end
            arm = tb_if.arm_we && (int'(tb_if.arm_sel) == i);
            if (due && (arm || !tb_if.disarm[i])) e_fire[i] = 1;
            if (arm) begin
                m_armed[i] = 1; m_rem[i] = d; m_period[i] = d;
                m_per[i] = tb_if.arm_periodic;
            end else if (tb_if.disarm[i]) begin
                m_armed[i] = 0;
            end else if (due) begin
                if (m_per[i]) m_rem[i] = m_period[i];
                else          m_armed[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        cmp("count", int'(tb_if.count), m_count);
        cmp("tick",  int'(tb_if.tick),  int'(e_tick));
        cmp("wrap",  int'(tb_if.wrap),  int'(e_wrap));
        cmp("armed", int'(tb_if.armed), int'(m_armed));
        cmp("fire",  int'(tb_if.fire),  int'(e_fire));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_in(input bit en, input bit clr, input bit we, input int sel,
                          input int dly, input bit per, input bit [2:0] dis);
        tb_if.enable       = en;
        tb_if.clear        = clr;
        tb_if.arm_we       = we;
        tb_if.arm_sel      = 2'(sel);
        tb_if.arm_delay    = 8'(dly);
        tb_if.arm_periodic = per;
        tb_if.disarm       = dis;
    endtask

    typedef struct {
        bit       en, clr, we;
        int       sel, dly;
        bit       per;
        bit [2:0] dis;
        int       ncyc;
        int       exp_count;
        bit [2:0] exp_armed;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int n, c, c0, guard, nf;
        bit saw_wrap;

        tbl[0] = '{1, 0, 0, 0, 0, 0, 3'b000,  8, 2, 3'b000};
        tbl[1] = '{1, 0, 1, 0, 3, 0, 3'b000,  1, 2, 3'b001};
        tbl[2] = '{1, 0, 0, 0, 0, 0, 3'b000, 12, 5, 3'b000};
        tbl[3] = '{1, 0, 1, 3, 2, 0, 3'b000,  1, 5, 3'b000};
        tbl[4] = '{1, 0, 1, 2, 0, 1, 3'b000,  1, 5, 3'b100};
        tbl[5] = '{1, 0, 0, 0, 0, 0, 3'b000,  1, 6, 3'b100};
        tbl[6] = '{1, 0, 0, 0, 0, 0, 3'b100,  1, 6, 3'b000};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 3'b000, 10, 6, 3'b000};
        tbl[8] = '{1, 0, 0, 0, 0, 0, 3'b000,  3, 7, 3'b000};
        tbl[9] = '{1, 1, 1, 1, 5, 0, 3'b000,  1, 0, 3'b000};

        set_in(0, 0, 0, 0, 0, 0, 3'b000);
        d_if.enable = 1; d_if.clear = 0; d_if.arm_we = 0; d_if.arm_sel = '0;
        d_if.arm_delay = '0; d_if.arm_periodic = 0; d_if.disarm = '0;
        model_reset();

        // Reset state, then default-parameter tick rate (DIV=50).
        @(negedge clk); @(negedge clk);
        reset = 0;
        check_all();
        cmp("dflt_count_rst", int'(d_if.count), 0);
        repeat (49_999) @(posedge clk);
        #1;
        cmp("dflt_count_49999", int'(d_if.count), 999);
        cmp("dflt_tick_49999", int'(d_if.tick), 0);
        @(posedge clk);
        #1;
        cmp("dflt_count_50000", int'(d_if.count), 1000);
        cmp("dflt_tick_50000", int'(d_if.tick), 1);
        d_if.enable = 0;
        check_all();

        // Table-driven vectors.
        for (int r = 0; r < 10; r++) begin
            set_in(tbl[r].en, tbl[r].clr, tbl[r].we, tbl[r].sel, tbl[r].dly,
                   tbl[r].per, tbl[r].dis);
            repeat (tbl[r].ncyc) step();
            cmp($sformatf("tbl%0d_count", r), int'(tb_if.count), tbl[r].exp_count);
            cmp($sformatf("tbl%0d_armed", r), int'(tb_if.armed), int'(tbl[r].exp_armed));
        end

        // Wrap: arm delay 10 at count 250 -> wrap at 255->0, fire at count 4.
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        guard = 0;
        do begin step(); guard++; end
        while (!(tb_if.count == 8'd250 && tb_if.tick) && guard < 2000);
        cmp("wrap_reach250_timeout", int'(guard < 2000), 1);
        set_in(1, 0, 1, 0, 10, 0, 3'b000);
        step();
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        saw_wrap = 0; guard = 0;
        do begin
            step(); guard++;
            if (tb_if.wrap && tb_if.count == 8'd0) saw_wrap = 1;
        end while (!tb_if.fire[0] && guard < 200);
        cmp("wrap_seen", int'(saw_wrap), 1);
        cmp("wrap_fire_count", int'(tb_if.count), 4);
        step();
        cmp("wrap_oneshot_disarmed", int'(tb_if.armed[0]), 0);

        // Freeze: enable low mid-period, resume after remaining prescale.
        repeat (1) step();
        c = int'(tb_if.count);
        set_in(0, 0, 0, 0, 0, 0, 3'b000);
        repeat (20) step();
        cmp("freeze_count", int'(tb_if.count), c);
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        n = 0;
        do begin step(); n++; end while (!tb_if.tick && n < 10);
        cmp("resume_clks", n, 2);

        // Periodic ch1 delay 5: fires at +5, +10, +15 ticks, then disarm.
        c0 = int'(tb_if.count);
        set_in(1, 0, 1, 1, 5, 1, 3'b000);
        step();
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        nf = 0; guard = 0;
        while (nf < 3 && guard < 200) begin
            step(); guard++;
            if (tb_if.fire[1]) begin
                nf++;
                cmp($sformatf("per_fire%0d_count", nf), int'(tb_if.count), (c0 + 5 * nf) % 256);
            end
        end
        cmp("per_fires", nf, 3);
        set_in(1, 0, 0, 0, 0, 0, 3'b010);
        step();
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        nf = 0;
        repeat (100) begin step(); if (tb_if.fire[1]) nf++; end
        cmp("per_after_disarm_fires", nf, 0);

        // Clear while ch0 periodic armed, then arm with delay 0.
        set_in(1, 0, 1, 0, 3, 1, 3'b000);
        step();
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        repeat (10) step();
        set_in(1, 1, 0, 0, 0, 0, 3'b000);
        step();
        cmp("clear_count", int'(tb_if.count), 0);
        cmp("clear_armed", int'(tb_if.armed), 0);
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        nf = 0;
        repeat (30) begin step(); if (tb_if.fire[0]) nf++; end
        cmp("clear_no_fire", nf, 0);
        c = int'(tb_if.count);
        set_in(1, 0, 1, 0, 0, 0, 3'b000);
        step();
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        guard = 0;
        do begin step(); guard++; end while (!tb_if.fire[0] && guard < 20);
        cmp("delay0_fire_count", int'(tb_if.count), (c + 1) % 256);

        // Async reset mid-count.
        set_in(1, 0, 1, 2, 7, 1, 3'b000);
        step();
        set_in(1, 0, 0, 0, 0, 0, 3'b000);
        repeat (5) step();
        reset = 1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 0;
        repeat (8) step();

        // Randomized stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            set_in($urandom_range(0, 9) != 0,
                   $urandom_range(0, 199) == 0,
                   $urandom_range(0, 5) == 0,
                   int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 8)),
                   1'($urandom_range(0, 1)),
                   {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 19) == 0)});
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
